ansi_vram_decoder: RTL
======================

Name: ansi_vram_decoder

Overview:
- Receive-side counterpart of the GPU serial frontend: consumes a byte stream from the serial receiver and parses printable characters, CR/LF and ANSI CSI sequences (cursor position H, SGR m, erase J).
- Writes the resulting 16-bit cells into VRAM through a master port. Cell format matches the GPU: [15] bold, [14] underline, [13:11] fg, [10:8] bg, [7:0] char.
- Sits between SerialReceiver and the VRAM arbiter, so a remote terminal stream can populate the framebuffer.

Parameters:
- COLS, 64: columns per row; a power of two; address = row*COLS + col (0-based).
- ROWS, 16: rows; ROWS*COLS = 1024 cells.
- MAX_PARAMS, 6: CSI numeric parameters stored; extra parameters are discarded.
- DEF_FG, 7: foreground after reset or SGR 0.
- DEF_BG, 0: background after reset or SGR 0.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- RX_DATA  in  8  received byte.
- RX_VALID  in  1  one-cycle strobe; RX_DATA is valid in that cycle.
- VRAM_LOCKED  in  1  another master (GPU) holds VRAM; writes must stall.
- VRAM_ENABLE  out  1  VRAM chip select.
- VRAM_WRITE  out  1  VRAM write strobe.
- VRAM_ADDR  out  10  cell address.
- VRAM_DATA_W  out  16  cell data.
- SIG_BUSY  out  1  decoder cannot accept a byte this cycle.
- SIG_DROP  out  1  sticky flag: a byte arrived while busy; cleared only by RESET.

Behaviour:
- Reset: state GROUND; cursor row=0, col=0; bold=0, ul=0, fg=DEF_FG, bg=DEF_BG; param count 0; all outputs 0.
- A byte is accepted only when RX_VALID=1 and SIG_BUSY=0. If RX_VALID=1 while SIG_BUSY=1, the byte is dropped and SIG_DROP is set.
- SIG_BUSY=1 in the WRITE, SGR and CLEAR states.
- GROUND state:
  - 0x20..0x7E: latch cell {bold,ul,fg,bg,byte}, go to WRITE.
  - 0x0D: col=0.
  - 0x0A: row=row+1, wrapping ROWS-1 to 0.
  - 0x1B: go to ESC.
  - Any other byte is ignored.
- ESC state:
  - '[' (0x5B): clear params and the private flag, go to CSI.
  - 0x1B: stay in ESC.
  - Anything else: go to GROUND.
- CSI state:
  - '0'..'9': param = param*10 + digit, saturating at 255 (8-bit).
  - ';': advance the parameter index; indices beyond MAX_PARAMS-1 are discarded.
  - '?': set the private flag.
  - 0x1B: go to ESC.
  - A final byte 0x40..0x7E dispatches the sequence.
  - Any other byte aborts to GROUND with no side effect.
  - Param count = number of separators + 1 if any digit or separator was seen, else 0.
- Dispatch (private flag set): every final byte is ignored, e.g. ?25l; go to GROUND.
- Dispatch 'H':
  - row = p0-1, col = p1-1. A missing or 0 parameter counts as 1.
  - Clamp to ROWS-1 and COLS-1.
  - Go to GROUND.
- Dispatch 'm':
  - Go to SGR, which handles one parameter per cycle in index order.
  - 0 gives defaults; 1 sets bold; 4 sets ul; 22 clears bold; 24 clears ul; 30..37 set fg=p-30; 40..47 set bg=p-40; other values are ignored.
  - Param count 0 behaves as a single 0.
  - After the last parameter, go to GROUND.
- Dispatch 'J' with p0==2:
  - Go to CLEAR and write 0x0000 to addresses 0..1023, one per unlocked cycle.
  - Cursor is unchanged.
  - Go to GROUND after address 1023.
  - Any other 'J' parameter is ignored.
- Other final bytes are ignored; go to GROUND.
- WRITE state:
  - VRAM_ENABLE=VRAM_WRITE=1 for exactly one cycle once VRAM_LOCKED=0; stall while locked.
  - Latency from byte acceptance to write strobe: 1 cycle when unlocked.
  - Then col+1. At COLS-1, col=0 and row+1. Row wraps from ROWS-1 to 0. There is no scrolling.
  - Go to GROUND.
- CLEAR also stalls while VRAM_LOCKED=1.
- The VRAM outputs are 0 whenever no write is in progress.
- RESET mid-sequence or mid-clear: immediate return to reset values. A partial clear is not resumed.

Optional Feature:
- Macro: ANSI_CURSOR_MOVE_EN.
- Defined: CSI n A/B/C/D move the cursor up/down/right/left by n (missing or 0 counts as 1), clamped at screen edges with no wrap; then go to GROUND.
- Undefined: A/B/C/D are unknown final bytes and are ignored; the cursor does not change.

Test Plan:
- Reset, then send "Hi" -> writes addr 0 data 0x3848 and addr 1 data 0x3869; cursor col=2.
- Send ESC "[3;10H" then "X" -> write addr 137 (2*64+9) data 0x3858.
- Send ESC "[0;1;4;32;45m" then "A" -> data 0xD541 (bold=1, ul=1, fg=2, bg=5); then ESC "[m" then "B" -> 0x3842.
- Send ESC "[99;99H" "Z" then "Q" -> first write at addr 1023; "Q" wraps to addr 0.
- Send ESC "[2J" with VRAM_LOCKED high for 10 cycles mid-clear -> 1024 zero writes, no skipped address; a byte strobed during the clear sets SIG_DROP=1.
- Send ESC "[?25l", ESC "[5x", ESC "[1G" -> no VRAM writes; a following "k" is written at the unchanged cursor position.

Source files
------------

// File: rtl/ansi_vram_decoder.sv
// Byte-stream terminal decoder: printable text, CR/LF and ANSI CSI (H, m, J) rendered into VRAM cells.
// Build option: define ANSI_CURSOR_MOVE_EN to enable CSI A/B/C/D relative cursor movement.
module ansi_vram_decoder #(
  parameter int COLS       = 64,
  parameter int ROWS       = 16,
  parameter int MAX_PARAMS = 6,
  parameter int DEF_FG     = 7,
  parameter int DEF_BG     = 0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  input  logic        VRAM_LOCKED,
  output logic        VRAM_ENABLE,
  output logic        VRAM_WRITE,
  output logic [9:0]  VRAM_ADDR,
  output logic [15:0] VRAM_DATA_W,
  output logic        SIG_BUSY,
  output logic        SIG_DROP,
  output logic [2:0]  DBG_STATE
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int PW = $clog2(MAX_PARAMS + 1);

  localparam logic [2:0] ST_GROUND = 3'd0;
  localparam logic [2:0] ST_ESC    = 3'd1;
  localparam logic [2:0] ST_CSI    = 3'd2;
  localparam logic [2:0] ST_WRITE  = 3'd3;
  localparam logic [2:0] ST_SGR    = 3'd4;
  localparam logic [2:0] ST_CLEAR  = 3'd5;

  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
  localparam logic [8:0]    ROW_LAST9 = 9'(ROWS - 1);
  localparam logic [8:0]    COL_LAST9 = 9'(COLS - 1);
  localparam logic [PW-1:0] PMAX      = PW'(MAX_PARAMS);
  localparam logic [9:0]    CLR_LAST  = 10'(ROWS * COLS - 1);

  // Valid/ready: a byte transfers on a clock edge where RX_VALID=1 and SIG_BUSY=0;
  // RX_VALID while SIG_BUSY=1 loses the byte and latches SIG_DROP.
  logic [2:0]    state;
  logic [RW-1:0] cursRow;
  logic [CW-1:0] cursCol;
  logic          bold, ul;
  logic [2:0]    fg, bg;
  logic [7:0]    params [2**PW];
  logic [PW-1:0] paramIdx, sgrIdx;
  logic          paramSeen, privFlag, dropFlag;
  logic [15:0]   cellData;
  logic [9:0]    clrAddr;

  logic          busy, accept, strobe;
  logic [PW-1:0] paramCount, sgrLast;
  logic [11:0]   digitAcc;
  logic [7:0]    digitNext, sgrVal, p0Less, p1Less;
  logic [RW-1:0] rowInc, hRow;
  logic [CW-1:0] hCol;

  always_comb begin
    busy       = (state == ST_WRITE) || (state == ST_SGR) || (state == ST_CLEAR);
    accept     = RX_VALID && !busy;
    strobe     = ((state == ST_WRITE) || (state == ST_CLEAR)) && !VRAM_LOCKED;
    paramCount = !paramSeen ? '0 : ((paramIdx >= PMAX - 1'b1) ? PMAX : paramIdx + 1'b1);
    sgrLast    = (paramCount == '0) ? '0 : paramCount - 1'b1;
    sgrVal     = params[sgrIdx];
    digitAcc   = 12'(params[paramIdx]) * 12'd10 + 12'(RX_DATA[3:0]);
    digitNext  = (digitAcc > 12'd255) ? 8'd255 : digitAcc[7:0];
    rowInc     = (cursRow == ROW_LAST) ? '0 : cursRow + 1'b1;
    // A missing or zero coordinate means the first row/column.
    p0Less     = (params[0] == 8'd0) ? 8'd0 : params[0] - 8'd1;
    p1Less     = (params[1] == 8'd0) ? 8'd0 : params[1] - 8'd1;
    hRow       = (9'(p0Less) > ROW_LAST9) ? ROW_LAST : p0Less[RW-1:0];
    hCol       = (9'(p1Less) > COL_LAST9) ? COL_LAST : p1Less[CW-1:0];
  end

`ifdef ANSI_CURSOR_MOVE_EN
  logic [8:0]    moveN, row9, col9, rowDn9, colRt9;
  logic [RW-1:0] rowUp, rowDn;
  logic [CW-1:0] colLf, colRt;
  always_comb begin
    moveN  = (params[0] == 8'd0) ? 9'd1 : 9'(params[0]);
    row9   = 9'(cursRow);
    col9   = 9'(cursCol);
    rowDn9 = row9 + moveN;
    colRt9 = col9 + moveN;
    rowUp  = (moveN > row9) ? '0 : RW'(row9 - moveN);
    colLf  = (moveN > col9) ? '0 : CW'(col9 - moveN);
    rowDn  = (rowDn9 > ROW_LAST9) ? ROW_LAST : rowDn9[RW-1:0];
    colRt  = (colRt9 > COL_LAST9) ? COL_LAST : colRt9[CW-1:0];
  end
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_GROUND;
      cursRow   <= '0;
      cursCol   <= '0;
      bold      <= 1'b0;
      ul        <= 1'b0;
      fg        <= 3'(DEF_FG);
      bg        <= 3'(DEF_BG);
      for (int i = 0; i < 2**PW; i++) params[i] <= 8'd0;
      paramIdx  <= '0;
      sgrIdx    <= '0;
      paramSeen <= 1'b0;
      privFlag  <= 1'b0;
      dropFlag  <= 1'b0;
      cellData  <= 16'd0;
      clrAddr   <= 10'd0;
    end else begin
      if (RX_VALID && busy) dropFlag <= 1'b1;
      case (state)
        ST_GROUND: if (accept) begin
          if (RX_DATA >= 8'h20 && RX_DATA <= 8'h7E) begin
            cellData <= {bold, ul, fg, bg, RX_DATA};
            state    <= ST_WRITE;
          end else if (RX_DATA == 8'h0D) cursCol <= '0;
          else if (RX_DATA == 8'h0A) cursRow <= rowInc;
          else if (RX_DATA == 8'h1B) state <= ST_ESC;
        end
        ST_ESC: if (accept) begin
          if (RX_DATA == 8'h5B) begin
            for (int i = 0; i < 2**PW; i++) params[i] <= 8'd0;
            paramIdx  <= '0;
            paramSeen <= 1'b0;
            privFlag  <= 1'b0;
            state     <= ST_CSI;
          end else if (RX_DATA != 8'h1B) state <= ST_GROUND;
        end
        ST_CSI: if (accept) begin
          if (RX_DATA >= 8'h30 && RX_DATA <= 8'h39) begin
            paramSeen <= 1'b1;
            if (paramIdx < PMAX) params[paramIdx] <= digitNext;
          end else if (RX_DATA == 8'h3B) begin
            paramSeen <= 1'b1;
            if (paramIdx != PMAX) paramIdx <= paramIdx + 1'b1;
          end else if (RX_DATA == 8'h3F) privFlag <= 1'b1;
          else if (RX_DATA == 8'h1B) state <= ST_ESC;
          else if (RX_DATA >= 8'h40 && RX_DATA <= 8'h7E) begin
            state <= ST_GROUND;
            if (!privFlag) begin
              case (RX_DATA)
                8'h48: begin cursRow <= hRow; cursCol <= hCol; end
                8'h6D: begin sgrIdx <= '0; state <= ST_SGR; end
                8'h4A: if (params[0] == 8'd2) begin clrAddr <= 10'd0; state <= ST_CLEAR; end
`ifdef ANSI_CURSOR_MOVE_EN
                8'h41: cursRow <= rowUp;
                8'h42: cursRow <= rowDn;
                8'h43: cursCol <= colRt;
                8'h44: cursCol <= colLf;
`endif
                default: ;
              endcase
            end
          end else state <= ST_GROUND;
        end
        ST_WRITE: if (!VRAM_LOCKED) begin
          state <= ST_GROUND;
          if (cursCol == COL_LAST) begin
            cursCol <= '0;
            cursRow <= rowInc;
          end else cursCol <= cursCol + 1'b1;
        end
        ST_SGR: begin
          if (sgrVal == 8'd0) begin
            bold <= 1'b0; ul <= 1'b0; fg <= 3'(DEF_FG); bg <= 3'(DEF_BG);
          end else if (sgrVal == 8'd1)  bold <= 1'b1;
          else if (sgrVal == 8'd4)  ul <= 1'b1;
          else if (sgrVal == 8'd22) bold <= 1'b0;
          else if (sgrVal == 8'd24) ul <= 1'b0;
          else if (sgrVal >= 8'd30 && sgrVal <= 8'd37) fg <= 3'(sgrVal - 8'd30);
          else if (sgrVal >= 8'd40 && sgrVal <= 8'd47) bg <= 3'(sgrVal - 8'd40);
          if (sgrIdx == sgrLast) state <= ST_GROUND;
          else sgrIdx <= sgrIdx + 1'b1;
        end
        ST_CLEAR: if (!VRAM_LOCKED) begin
          if (clrAddr == CLR_LAST) state <= ST_GROUND;
          else clrAddr <= clrAddr + 10'd1;
        end
        default: state <= ST_GROUND;
      endcase
    end
  end

  // The bus is driven only during the cycle a write actually commits.
  always_comb begin
    VRAM_ENABLE = strobe;
    VRAM_WRITE  = strobe;
    VRAM_ADDR   = 10'd0;
    VRAM_DATA_W = 16'd0;
    if (strobe && state == ST_WRITE) begin
      VRAM_ADDR   = 10'({cursRow, cursCol});
      VRAM_DATA_W = cellData;
    end else if (strobe) VRAM_ADDR = clrAddr;
    SIG_BUSY  = busy;
    SIG_DROP  = dropFlag;
    DBG_STATE = state;
  end
endmodule
